// File: rtl/repeated_subtraction_divider.sv
// Sequential 32-bit unsigned divider using repeated subtraction.
// One subtract-and-count step is taken on each clock-enable pulse; the
// packed result is {quotient, remainder}, straight from registers.
module repeated_subtraction_divider #(
  parameter int STEP_DIV = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [63:0] Out,
  output logic        Done
);

  localparam int CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [31:0]       remainder;
  logic [31:0]       quotient;
  logic [31:0]       divisor;
  logic [CNT_W-1:0]  ce_count;

  logic              ce;
  logic              enable;
  logic              div_zero;
  logic              write_en;
  logic [31:0]       sub_a;
  logic [31:0]       sub_b;
  logic [31:0]       diff;

  // Clock-enable pulse generator: wraps every STEP_DIV clocks and
  // restarts on Start so the first step lands STEP_DIV clocks later.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      ce_count <= '0;
    end else if (Start || ce_count == CNT_LAST) begin
      ce_count <= '0;
    end else begin
      ce_count <= ce_count + CNT_W'(1);
    end
  end

  assign ce = (ce_count == CNT_LAST);

  // A step is possible while the remainder still covers the divisor.
  assign enable   = !(remainder < divisor);
  assign div_zero = (divisor == 32'd0);

  // Register write enable: the single AND of clock enable and step enable,
  // qualified by being in RUN with a usable divisor.
  assign write_en = ce & enable & ~div_zero & (state == RUN);

  // Subtractor as an adder of the inverted divisor with carry-in 1.
  // Inputs are zeroed when no step is taken, so its output is 0 then.
  assign sub_a = write_en ? remainder : 32'd0;
  assign sub_b = write_en ? divisor   : 32'd0;
  assign diff  = sub_a + ~sub_b + 32'd1;

  // Control FSM and datapath registers; Start overrides any stepping.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      remainder <= 32'd0;
      quotient  <= 32'd0;
      divisor   <= 32'd0;
      Done      <= 1'b0;
    end else if (Start) begin
      state     <= RUN;
      remainder <= A;
      quotient  <= 32'd0;
      divisor   <= B;
      Done      <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (ce) begin
            if (div_zero) begin
              quotient <= 32'hFFFF_FFFF;
              state    <= DONE;
              Done     <= 1'b1;
            end else if (write_en) begin
              remainder <= diff;
              quotient  <= quotient + 32'd1;
            end else begin
              state <= DONE;
              Done  <= 1'b1;
            end
          end
        end
        DONE: begin
          Done <= 1'b1;
        end
        IDLE: begin
          Done <= 1'b0;
        end
        default: begin
          state <= IDLE;
          Done  <= 1'b0;
        end
      endcase
    end
  end

  assign Out = {quotient, remainder};

endmodule

// File: tb/tb_repeated_subtraction_divider.sv
// Testbench for repeated_subtraction_divider: directed table, random
// vectors against an arithmetic model, and multi-cycle corner sequences.
module tb_repeated_subtraction_divider;

  logic        clk;
  logic        reset;
  logic        start0, start3;
  logic [31:0] a0, b0, a3, b3;
  logic [63:0] out0, out3;
  logic        done0, done3;

  int checks = 0;
  int errors = 0;

  repeated_subtraction_divider #(.STEP_DIV(1)) dut1 (
    .Clk(clk), .Reset(reset), .Start(start0), .A(a0), .B(b0),
    .Out(out0), .Done(done0)
  );

  repeated_subtraction_divider #(.STEP_DIV(3)) dut3 (
    .Clk(clk), .Reset(reset), .Start(start3), .A(a3), .B(b3),
    .Out(out3), .Done(done3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    int          lat;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%016h", name, act);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return {32'hFFFF_FFFF, a};
    return {a / b, a % b};
  endfunction

  function automatic int model_lat(input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 1;
    return int'(a / b) + 1;
  endfunction

  // Present Start for exactly one edge; returns #1 after that edge.
  task automatic pulse(input int sel, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    if (sel == 0) begin start0 = 1'b1; a0 = a; b0 = b; end
    else          begin start3 = 1'b1; a3 = a; b3 = b; end
    @(posedge clk); #1;
    start0 = 1'b0;
    start3 = 1'b0;
  endtask

  task automatic wait_done(input int sel, input string name,
                           input logic [63:0] exp_out, input int exp_lat);
    int   cycles = 0;
    logic d;
    d = (sel == 0) ? done0 : done3;
    while (!d && cycles < exp_lat + 20) begin
      @(posedge clk); #1;
      cycles++;
      d = (sel == 0) ? done0 : done3;
    end
    check({name, " latency"}, 64'(cycles), 64'(exp_lat));
    check({name, " out"}, (sel == 0) ? out0 : out3, exp_out);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [63:0] held;

    vecs[0] = '{32'h0005_4123, 32'h0000_547B, 32'h0000_000F, 32'h0000_4DEE, 16};
    vecs[1] = '{32'h0000_0005, 32'h0000_0007, 32'h0000_0000, 32'h0000_0005, 1};
    vecs[2] = '{32'h0000_0064, 32'h0000_0064, 32'h0000_0001, 32'h0000_0000, 2};
    vecs[3] = '{32'h1234_5678, 32'h0000_0000, 32'hFFFF_FFFF, 32'h1234_5678, 1};
    vecs[4] = '{32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};
    vecs[5] = '{32'h0000_0000, 32'h0000_0005, 32'h0000_0000, 32'h0000_0000, 1};
    vecs[6] = '{32'h0000_0007, 32'h0000_0001, 32'h0000_0007, 32'h0000_0000, 8};
    vecs[7] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 2};
    vecs[8] = '{32'h0000_03E8, 32'h0000_0021, 32'h0000_001E, 32'h0000_000A, 31};

    reset = 1'b0;
    start0 = 1'b0; start3 = 1'b0;
    a0 = 32'hDEAD_BEEF; b0 = 32'h1; a3 = 32'hDEAD_BEEF; b3 = 32'h1;
    repeat (3) @(posedge clk);
    #1;
    check("reset out", out0, 64'd0);
    check("reset done", 64'(done0), 64'd0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle out", out0, 64'd0);
    check("idle done", 64'(done0), 64'd0);

    // Directed table
    for (int i = 0; i < 9; i++) begin
      pulse(0, vecs[i].a, vecs[i].b);
      check($sformatf("vec%0d done low after start", i), 64'(done0), 64'd0);
      wait_done(0, $sformatf("vec%0d", i), {vecs[i].q, vecs[i].r}, vecs[i].lat);
    end

    // Result holds while A/B wander without Start
    held = out0;
    a0 = 32'h0BAD_F00D; b0 = 32'h3;
    repeat (4) @(posedge clk);
    #1;
    check("hold out", out0, held);
    check("hold done", 64'(done0), 64'd1);

    // Random vectors against the arithmetic model
    for (int i = 0; i < 24; i++) begin
      case (i % 3)
        0: begin ra = $urandom_range(0, 3000); rb = $urandom_range(0, 40); end
        1: begin ra = $urandom; rb = (ra >> $urandom_range(0, 8)) + $urandom_range(0, 5); end
        default: begin ra = $urandom_range(0, 100); rb = $urandom; end
      endcase
      pulse(0, ra, rb);
      wait_done(0, $sformatf("rand%0d a=%0h b=%0h", i, ra, rb), model(ra, rb), model_lat(ra, rb));
    end

    // Mid-run restart: second Start aborts the first division
    pulse(0, 32'd1000, 32'd1);
    repeat (4) @(posedge clk);
    #1;
    check("abort running", 64'(done0), 64'd0);
    pulse(0, 32'd10, 32'd3);
    wait_done(0, "restart", 64'h0000_0003_0000_0001, 4);

    // Asynchronous reset between edges clears outputs immediately
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("async reset out", out0, 64'd0);
    check("async reset done", 64'(done0), 64'd0);
    #2;
    reset = 1'b1;

    // Divided clock enable
    pulse(1, 32'd9, 32'd4);
    wait_done(1, "step3 9/4", 64'h0000_0002_0000_0001, 9);
    for (int i = 0; i < 4; i++) begin
      ra = $urandom_range(0, 200);
      rb = $urandom_range(0, 30);
      pulse(1, ra, rb);
      wait_done(1, $sformatf("step3 rand%0d a=%0h b=%0h", i, ra, rb),
                model(ra, rb), 3 * model_lat(ra, rb));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
